pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Fetch-stage PC generator, directly upstream of the branch-resolution logic.
//   Holds the architectural fetch PC and issues instruction-memory requests.
//   Advances sequentially by 4, or redirects when flow_change/br_addr fires.
//   Generates IF/ID flush bubbles and traps on misaligned redirect targets.
// PARAMETERS
//   RESET_PC      32'h0000_0000  first fetch address after reset
//   FLUSH_CYCLES  2              flush pulses after a redirect (1..7)
// PORTS
//   clk            in   1   system clock, all state on posedge
//   rst            in   1   synchronous, active-high reset
//   stall          in   1   hazard stall from decode: hold PC, no new request accept
//   flow_change    in   1   redirect request (already stall-gated upstream)
//   br_addr        in   32  redirect target
//   imem_rdy       in   1   imem accepts imem_req/imem_addr this cycle
//   imem_req       out  1   fetch request valid
//   imem_addr      out  32  fetch address (== current PC register)
//   pc_IF          out  32  PC of most recently accepted fetch
//   pc_plus4       out  32  pc_IF + 4 (combinational, mod 2^32)
//   flush          out  1   kill the instruction in IF/ID this cycle
//   misalign_trap  out  1   sticky: redirect target had br_addr[1:0] != 0
//   trap_addr      out  32  offending target, valid while misalign_trap=1
// BEHAVIOUR
//   Reset (rst=1 at posedge), all registered: pc=RESET_PC, pc_IF=RESET_PC,
//     imem_req=0, flush=0, misalign_trap=0, trap_addr=0, flush_cnt=0, state=BOOT.
//   Priority, highest first: rst > flow_change > stall > sequential advance.
//   FSM states:
//     BOOT:  imem_req=0. Next cycle -> FETCH, unconditionally.
//     FETCH: imem_req=1, imem_addr=pc. Request accepted when imem_req&imem_rdy&~stall:
//            pc_IF<=pc, pc<=pc+4. If imem_rdy=0 or stall=1, hold pc and imem_addr
//            stable (request stays asserted, address must not change).
//     TRAP:  imem_req=0, pc frozen, flush=1 every cycle. Exit only via rst.
//   Redirect: flow_change=1 with br_addr[1:0]==0, in FETCH:
//     pc<=br_addr next edge, ignoring imem_rdy and stall that cycle;
//     any pending un-accepted request is abandoned (imem_addr changes).
//     flush_cnt<=FLUSH_CYCLES; flush=(flush_cnt!=0), registered, so the first
//     flush is the cycle after flow_change, lasting exactly FLUSH_CYCLES cycles.
//     flush_cnt decrements every cycle, including stalled cycles.
//   Redirect while flush_cnt!=0: newest target wins, counter reloads to FLUSH_CYCLES.
//   Misaligned redirect (flow_change=1, br_addr[1:0]!=0): next edge state=TRAP,
//     misalign_trap<=1, trap_addr<=br_addr, pc unchanged. Further flow_change ignored.
//   flow_change in BOOT: taken as a redirect (same rules); state still -> FETCH.
//   Arithmetic: pc+4 and pc_plus4 wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
//   pc_IF changes only on an accepted request; never on redirect alone.
//   No combinational path from flow_change/br_addr to imem_addr (registered only).
// TESTING
//   1 Reset, then imem_rdy=1, stall=0 -> imem_req rises 1 cycle after rst drop;
//     imem_addr 0,4,8,C on consecutive cycles; pc_IF trails imem_addr by 1.
//   2 imem_rdy=0 for 3 cycles at addr 0x10 -> imem_addr held at 0x10, imem_req=1,
//     pc_IF unchanged; rdy=1 -> 0x10 accepted, next imem_addr=0x14.
//   3 flow_change=1, br_addr=0x200 with stall=1 and imem_rdy=0 -> next imem_addr=0x200;
//     flush=1 for exactly 2 cycles, starting the cycle after flow_change.
//   4 Redirects to 0x100, then 0x300 one cycle later -> imem_addr 0x100 then 0x300;
//     flush high for 3 consecutive cycles (counter reload).
//   5 flow_change=1, br_addr=0x102 -> misalign_trap=1, trap_addr=0x102, imem_req=0,
//     flush=1 until rst; a later flow_change to 0x400 is ignored.
//   6 RESET_PC=32'hFFFF_FFF8, imem_rdy=1 -> imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000;
//     pc_plus4=0 when pc_IF=FFFF_FFFC; rst asserted mid-redirect -> pc=RESET_PC, flush=0.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Fetch-unit boundary signals: decode/branch controls in, instruction-memory request and status out.
interface pc_fetch_if;
    logic        stall;
    logic        flow_change;
    logic [31:0] br_addr;
    logic        imem_rdy;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_IF;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        misalign_trap;
    logic [31:0] trap_addr;

    modport master (
        input  stall, flow_change, br_addr, imem_rdy,
        output imem_req, imem_addr, pc_IF, pc_plus4, flush, misalign_trap, trap_addr
    );

    modport slave (
        output stall, flow_change, br_addr, imem_rdy,
        input  imem_req, imem_addr, pc_IF, pc_plus4, flush, misalign_trap, trap_addr
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC generator: sequential +4 fetch with imem handshake, redirects with
// IF/ID flush bubbles, and a sticky trap on misaligned redirect targets.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic        clk,
    input logic        rst,
    pc_fetch_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, TRAP} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pc_if, pc_if_nxt;
    logic [31:0] trap_addr, trap_addr_nxt;
    logic [2:0]  flush_cnt, flush_cnt_nxt;
    logic        trap, trap_nxt;
    logic        redirect, misaligned, accept;

    // Redirects are honoured in BOOT and FETCH; once trapped only rst gets us out.
    assign redirect   = bus.flow_change && (state != TRAP);
    assign misaligned = (bus.br_addr[1:0] != 2'b00);
    assign accept     = (state == FETCH) && bus.imem_rdy && !bus.stall && !redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            pc_if     <= RESET_PC;
            trap      <= 1'b0;
            trap_addr <= 32'h0;
            flush_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            pc_if     <= pc_if_nxt;
            trap      <= trap_nxt;
            trap_addr <= trap_addr_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        pc_if_nxt     = pc_if;
        trap_nxt      = trap;
        trap_addr_nxt = trap_addr;
        flush_cnt_nxt = (flush_cnt != 3'd0) ? flush_cnt - 3'd1 : 3'd0;

        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   state_nxt = FETCH;
            TRAP:    state_nxt = TRAP;
            default: state_nxt = BOOT;
        endcase

        // A redirect overrides any pending request, even one stalled or not yet accepted.
        if (redirect && misaligned) begin
            state_nxt     = TRAP;
            trap_nxt      = 1'b1;
            trap_addr_nxt = bus.br_addr;
        end else if (redirect) begin
            pc_nxt        = bus.br_addr;
            flush_cnt_nxt = FLUSH_LOAD;
        end else if (accept) begin
            pc_if_nxt = pc;
            pc_nxt    = pc + 32'd4;
        end
    end

    assign bus.imem_req      = (state == FETCH);
    assign bus.imem_addr     = pc;
    assign bus.pc_IF         = pc_if;
    assign bus.pc_plus4      = pc_if + 32'd4;
    assign bus.flush         = (flush_cnt != 3'd0) || (state == TRAP);
    assign bus.misalign_trap = trap;
    assign bus.trap_addr     = trap_addr;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: two instances (reset PC 0 and FFFF_FFF8) share stimulus; a
// behavioural model feeds a per-cycle scoreboard that a negedge monitor drains.
module tb_pc_fetch_unit;
    localparam logic [31:0] RPC0  = 32'h0000_0000;
    localparam logic [31:0] RPC1  = 32'hFFFF_FFF8;
    localparam int          FLUSH = 2;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] pc_if;
        logic [31:0] trap_addr;
        int          flush_left;
        bit          trapped;
        bit          booting;
    } model_t;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc_if;
        logic [31:0] plus4;
        logic        flush;
        logic        trap;
        logic [31:0] trap_addr;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flow_change, imem_rdy;
    logic [31:0] br_addr;

    int checks   = 0;
    int failures = 0;

    pair_t  sb[$];
    model_t m0, m1;

    pc_fetch_if bus0();
    pc_fetch_if bus1();

    assign bus0.stall       = stall;
    assign bus0.flow_change = flow_change;
    assign bus0.br_addr     = br_addr;
    assign bus0.imem_rdy    = imem_rdy;
    assign bus1.stall       = stall;
    assign bus1.flow_change = flow_change;
    assign bus1.br_addr     = br_addr;
    assign bus1.imem_rdy    = imem_rdy;

    pc_fetch_unit #(.RESET_PC(RPC0), .FLUSH_CYCLES(FLUSH)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.master)
    );
    pc_fetch_unit #(.RESET_PC(RPC1), .FLUSH_CYCLES(FLUSH)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.master)
    );

    always #5 clk = ~clk;

    function automatic model_t model_reset(input logic [31:0] rpc);
        model_t n;
        n.rpc        = rpc;
        n.pc         = rpc;
        n.pc_if      = rpc;
        n.trap_addr  = 32'h0;
        n.flush_left = 0;
        n.trapped    = 1'b0;
        n.booting    = 1'b1;
        return n;
    endfunction

    function automatic exp_t model_out(input model_t m);
        exp_t e;
        e.req       = !m.booting && !m.trapped;
        e.addr      = m.pc;
        e.pc_if     = m.pc_if;
        e.plus4     = m.pc_if + 32'd4;
        e.flush     = m.trapped || (m.flush_left > 0);
        e.trap      = m.trapped;
        e.trap_addr = m.trap_addr;
        return e;
    endfunction

    function automatic model_t model_next(input model_t m, input bit r, input bit st,
                                          input bit fc, input logic [31:0] br, input bit rdy);
        model_t n = m;
        if (r) return model_reset(m.rpc);
        if (n.flush_left > 0) n.flush_left = n.flush_left - 1;
        if (m.trapped) return n;
        if (fc) begin
            if (br % 4 != 0) begin
                n.trapped   = 1'b1;
                n.trap_addr = br;
            end else begin
                n.pc         = br;
                n.flush_left = FLUSH;
            end
            n.booting = 1'b0;
        end else if (m.booting) begin
            n.booting = 1'b0;
        end else if (rdy && !st) begin
            n.pc_if = m.pc;
            n.pc    = m.pc + 32'd4;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit st, input bit fc, input logic [31:0] br, input bit rdy);
        pair_t p;
        rst         = r;
        stall       = st;
        flow_change = fc;
        br_addr     = br;
        imem_rdy    = rdy;
        p.a = model_out(m0);
        p.b = model_out(m1);
        sb.push_back(p);
        m0 = model_next(m0, r, st, fc, br, rdy);
        m1 = model_next(m1, r, st, fc, br, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, rdy);
    endtask

    // Monitor: every cycle the DUTs present a full output set, compared against the oldest entry.
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                p = sb.pop_front();
                chk("dut0.imem_req",   {31'h0, bus0.imem_req},      {31'h0, p.a.req});
                chk("dut0.imem_addr",  bus0.imem_addr,              p.a.addr);
                chk("dut0.pc_IF",      bus0.pc_IF,                  p.a.pc_if);
                chk("dut0.pc_plus4",   bus0.pc_plus4,               p.a.plus4);
                chk("dut0.flush",      {31'h0, bus0.flush},         {31'h0, p.a.flush});
                chk("dut0.trap",       {31'h0, bus0.misalign_trap}, {31'h0, p.a.trap});
                chk("dut0.trap_addr",  bus0.trap_addr,              p.a.trap_addr);
                chk("dut1.imem_req",   {31'h0, bus1.imem_req},      {31'h0, p.b.req});
                chk("dut1.imem_addr",  bus1.imem_addr,              p.b.addr);
                chk("dut1.pc_IF",      bus1.pc_IF,                  p.b.pc_if);
                chk("dut1.pc_plus4",   bus1.pc_plus4,               p.b.plus4);
                chk("dut1.flush",      {31'h0, bus1.flush},         {31'h0, p.b.flush});
                chk("dut1.trap",       {31'h0, bus1.misalign_trap}, {31'h0, p.b.trap});
                chk("dut1.trap_addr",  bus1.trap_addr,              p.b.trap_addr);
            end
        end
    end

    initial begin
        int trap_age;
        logic [31:0] br;
        bit r, st, fc, rdy;

        rst = 1'b1; stall = 1'b0; flow_change = 1'b0; br_addr = 32'h0; imem_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        m0 = model_reset(RPC0);
        m1 = model_reset(RPC1);

        // Sequential fetch from reset, then imem back-pressure at 0x10.
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(5, 1'b1);
        idle(3, 1'b0);
        idle(2, 1'b1);

        // Redirect while stalled and imem not ready.
        cyc(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
        idle(4, 1'b1);

        // Back-to-back redirects reload the flush counter.
        cyc(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
        idle(5, 1'b1);

        // Misaligned redirect traps; a later redirect is ignored.
        cyc(1'b0, 1'b0, 1'b1, 32'h102, 1'b1);
        idle(3, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'h400, 1'b1);
        idle(3, 1'b1);

        // Reset releases the trap; reset during a redirect wins.
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(4, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 32'h90, 1'b1);
        idle(4, 1'b1);

        // Redirects issued in BOOT, aligned and misaligned.
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1);
        idle(3, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0043, 1'b1);
        idle(2, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect near the top of the address space to exercise wrap.
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1);
        idle(6, 1'b1);

        trap_age = 0;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0) || (trap_age > 12);
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            fc  = ($urandom_range(0, 7) == 0);
            br  = $urandom;
            if ($urandom_range(0, 3) == 0) br = 32'hFFFF_FFE0 | (br & 32'h1F);
            if ($urandom_range(0, 15) != 0) br[1:0] = 2'b00;
            cyc(r, st, fc, br, rdy);
            trap_age = m0.trapped ? trap_age + 1 : 0;
        end

        idle(2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
